// File: rtl/wavetable_reader.sv
`default_nettype none
// ==========================================================================
// wavetable_reader : DDS phase accumulator fetching one ROM sample per tick
// Revision: 1.0
// ==========================================================================
module wavetable_reader #(
  parameter int width_p       = 12,
  parameter int depth_p       = 512,
  parameter int phase_width_p = 24
) (
  input  logic                       clk_i,
  input  logic                       reset_ni,
  input  logic                       en_i,
  input  logic                       tick_i,
  input  logic [phase_width_p-1:0]   ftw_i,
  input  logic                       ftw_valid_i,
  input  logic                       phase_clr_i,
  output logic [$clog2(depth_p)-1:0] addr_o,
  input  logic [width_p-1:0]         rom_data_i,
  output logic [width_p-1:0]         data_o,
  output logic                       valid_o,
  input  logic                       ready_i,
  output logic                       overrun_o,
  input  logic                       overrun_clr_i
);

  localparam int C_ADDR_W = $clog2(depth_p);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_WAIT  = 2'd2,
    ST_OUT   = 2'd3
  } state_t;

  state_t                   state_q,   state_d;
  logic [phase_width_p-1:0] phase_q,   phase_d;
  logic [phase_width_p-1:0] ftw_q,     ftw_d;
  logic [C_ADDR_W-1:0]      addr_q,    addr_d;
  logic [width_p-1:0]       data_q,    data_d;
  logic                     overrun_q, overrun_d;

  logic w_tick_en;
  logic w_accept;
  logic w_drop;

  assign w_tick_en = tick_i & en_i;
  assign w_accept  = w_tick_en & (state_q == ST_IDLE);
  assign w_drop    = w_tick_en & (state_q != ST_IDLE);

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q   <= ST_IDLE;
      phase_q   <= '0;
      ftw_q     <= '0;
      addr_q    <= '0;
      data_q    <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      ftw_q     <= ftw_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      overrun_q <= overrun_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    ftw_d     = ftw_valid_i ? ftw_i : ftw_q;
    addr_d    = addr_q;
    data_d    = data_q;
    overrun_d = overrun_q;

    unique case (state_q)
      ST_IDLE:  if (w_accept) state_d = ST_FETCH;
      ST_FETCH: state_d = ST_WAIT;
      ST_WAIT: begin
        data_d  = rom_data_i;
        state_d = ST_OUT;
      end
      ST_OUT:   if (ready_i) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase

    if (w_accept) begin
      addr_d = phase_clr_i ? '0 : phase_q[phase_width_p-1 -: C_ADDR_W];
    end

    // Dropped ticks still advance the phase so pitch is preserved under overrun.
    if (phase_clr_i) begin
      phase_d = w_accept ? ftw_q : '0;
    end else if (w_tick_en) begin
      phase_d = phase_q + ftw_q;
    end

    if (w_drop) begin
      overrun_d = 1'b1;
    end else if (overrun_clr_i) begin
      overrun_d = 1'b0;
    end
  end

  assign addr_o    = addr_q;
  assign data_o    = data_q;
  assign valid_o   = (state_q == ST_OUT);
  assign overrun_o = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_wavetable_reader.sv
`default_nettype none
// tb_wavetable_reader : randomized + directed scoreboard bench for wavetable_reader
module tb_wavetable_reader;

  localparam int W  = 12;
  localparam int D  = 512;
  localparam int PW = 24;
  localparam int AW = 9;

  logic          clk_i         = 1'b0;
  logic          reset_ni      = 1'b1;
  logic          en_i          = 1'b0;
  logic          tick_i        = 1'b0;
  logic [PW-1:0] ftw_i         = '0;
  logic          ftw_valid_i   = 1'b0;
  logic          phase_clr_i   = 1'b0;
  logic          ready_i       = 1'b1;
  logic          overrun_clr_i = 1'b0;
  logic [AW-1:0] addr_o;
  logic [W-1:0]  rom_data_i;
  logic [W-1:0]  data_o;
  logic          valid_o;
  logic          overrun_o;

  wavetable_reader #(
    .width_p      (W),
    .depth_p      (D),
    .phase_width_p(PW)
  ) dut (
    .clk_i        (clk_i),
    .reset_ni     (reset_ni),
    .en_i         (en_i),
    .tick_i       (tick_i),
    .ftw_i        (ftw_i),
    .ftw_valid_i  (ftw_valid_i),
    .phase_clr_i  (phase_clr_i),
    .addr_o       (addr_o),
    .rom_data_i   (rom_data_i),
    .data_o       (data_o),
    .valid_o      (valid_o),
    .ready_i      (ready_i),
    .overrun_o    (overrun_o),
    .overrun_clr_i(overrun_clr_i)
  );

  always #5 clk_i = ~clk_i;

  // Registered sawtooth ROM: mem[i] = 4*i
  always @(posedge clk_i) rom_data_i <= {1'b0, addr_o, 2'b00};

  typedef struct {
    logic [AW-1:0] addr;
    logic [W-1:0]  data;
    int            acc;
  } exp_t;

  exp_t          q[$];
  logic [PW-1:0] m_phase = '0;
  logic [PW-1:0] m_ftw   = '0;
  bit            m_busy  = 1'b0;
  int            m_acc   = 0;
  bit            m_ovr   = 1'b0;
  int            edge_no = 0;
  int            n_cmp   = 0;
  int            n_bad   = 0;
  bit            prev_valid = 1'b0;

  function automatic void check(string nm, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endfunction

  // Reference behaviour for one rising edge, using the inputs the DUT just sampled.
  // A transaction occupies the reader from its accepting edge until the first edge
  // at least three edges later on which ready_i is high.
  function automatic void model_edge();
    bit   te;
    bit   was_busy;
    exp_t e;
    edge_no++;
    te       = tick_i && en_i;
    was_busy = m_busy;
    if (m_busy && (edge_no - m_acc >= 3) && ready_i) m_busy = 1'b0;
    if (te && !was_busy) begin
      e.addr = phase_clr_i ? '0 : m_phase[PW-1 -: AW];
      e.data = W'(4 * int'(e.addr));
      e.acc  = edge_no;
      q.push_back(e);
      m_phase = phase_clr_i ? m_ftw : m_phase + m_ftw;
      m_busy  = 1'b1;
      m_acc   = edge_no;
    end else if (te) begin
      m_ovr   = 1'b1;
      m_phase = phase_clr_i ? '0 : m_phase + m_ftw;
    end else if (phase_clr_i) begin
      m_phase = '0;
    end
    if (!(te && was_busy) && overrun_clr_i) m_ovr = 1'b0;
    if (ftw_valid_i) m_ftw = ftw_i;
  endfunction

  function automatic void model_reset();
    m_phase = '0;
    m_ftw   = '0;
    m_busy  = 1'b0;
    m_ovr   = 1'b0;
    q.delete();
  endfunction

  // Monitor: sample between edges, compare against the scoreboard head.
  always @(negedge clk_i) begin
    if (reset_ni) begin
      check("overrun", overrun_o, m_ovr);
      if (valid_o && !prev_valid) begin
        if (q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL spurious_valid: got valid_o=1 expected no pending sample (t=%0t)", $time);
        end else begin
          check("valid_latency", edge_no - q[0].acc, 2);
        end
      end
      if (valid_o && q.size() > 0) begin
        check("data", data_o, q[0].data);
        if (ready_i) begin
          check("addr", addr_o, q[0].addr);
          void'(q.pop_front());
        end
      end
      prev_valid = valid_o;
    end else begin
      prev_valid = 1'b0;
    end
  end

  task automatic cyc(int n);
    repeat (n) begin
      @(posedge clk_i);
      model_edge();
      #1;
      tick_i        = 1'b0;
      ftw_valid_i   = 1'b0;
      phase_clr_i   = 1'b0;
      overrun_clr_i = 1'b0;
    end
  endtask

  task automatic load_ftw(logic [PW-1:0] f);
    ftw_i       = f;
    ftw_valid_i = 1'b1;
    cyc(1);
  endtask

  task automatic tick(bit clr = 1'b0);
    tick_i      = 1'b1;
    phase_clr_i = clr;
    cyc(1);
  endtask

  task automatic do_reset();
    #2;
    reset_ni = 1'b0;
    #1;
    check("rst_valid", valid_o, 0);
    check("rst_data", data_o, 0);
    check("rst_addr", addr_o, 0);
    check("rst_overrun", overrun_o, 0);
    model_reset();
    @(negedge clk_i);
    @(negedge clk_i);
    reset_ni = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    en_i    = 1'b1;
    ready_i = 1'b1;
    #1;
    reset_ni = 1'b0;
    #1;
    check("rst_valid", valid_o, 0);
    check("rst_data", data_o, 0);
    check("rst_addr", addr_o, 0);
    check("rst_overrun", overrun_o, 0);
    #10;
    reset_ni = 1'b1;

    // steady stepping
    load_ftw(24'h008000);
    repeat (6) begin
      tick();
      cyc(7);
    end

    // wrap-around
    do_reset();
    load_ftw(24'hFF8000);
    tick();
    cyc(7);
    load_ftw(24'h008000);
    tick();
    check("wrap_addr_top", addr_o, D - 1);
    cyc(7);
    tick();
    check("wrap_addr_zero", addr_o, 0);
    cyc(7);

    // backpressure with an overrun tick during OUT
    ready_i = 1'b0;
    tick();
    cyc(4);
    tick();
    cyc(5);
    check("overrun_set", overrun_o, 1);
    ready_i = 1'b1;
    cyc(2);
    overrun_clr_i = 1'b1;
    cyc(1);
    check("overrun_cleared", overrun_o, 0);
    tick();
    cyc(7);

    // clear coincident with tick
    load_ftw(24'h010000);
    tick(1'b1);
    check("clr_tick_addr", addr_o, 0);
    cyc(7);
    tick();
    check("clr_next_addr", addr_o, 2);
    cyc(7);

    // asynchronous reset while in WAIT
    tick();
    cyc(1);
    do_reset();
    tick();
    check("post_reset_addr", addr_o, 0);
    cyc(7);

    // ticks ignored while disabled
    load_ftw(24'h008000);
    tick();
    cyc(7);
    en_i = 1'b0;
    repeat (5) begin
      tick();
      cyc(3);
    end
    en_i = 1'b1;
    check("en0_overrun", overrun_o, 0);
    tick();
    check("en0_addr", addr_o, 1);
    cyc(7);

    // randomized traffic
    for (int i = 0; i < 800; i++) begin
      tick_i        = ($urandom_range(0, 5) == 0);
      en_i          = ($urandom_range(0, 9) != 0);
      ready_i       = ($urandom_range(0, 9) < 7);
      phase_clr_i   = ($urandom_range(0, 29) == 0);
      overrun_clr_i = ($urandom_range(0, 14) == 0);
      ftw_valid_i   = ($urandom_range(0, 19) == 0);
      ftw_i         = PW'($urandom);
      cyc(1);
    end

    // drain
    en_i    = 1'b0;
    ready_i = 1'b1;
    for (int i = 0; i < 20 && q.size() != 0; i++) cyc(1);
    check("drain_empty", q.size(), 0);
    cyc(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
